param_mode_counter: RTL and testbench

Parametrised up/down counter for TinyTapeout user designs. It generalises the basic 4-bit up/down counter with the following features:
- configurable width and terminal value (modulus)
- programmable step size
- synchronous load and clear
- four run-time boundary modes: wrap, saturate, bounce and one-shot

It sits between input-pin decode and output-pin mux logic, and drives status flags for downstream display or sequencing logic.

---
 rtl/param_mode_counter.sv | 105 ++++++++++
 tb/tb_param_mode_counter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mode_counter.sv
// Parametrised up/down counter with programmable step, load/clear, and
// wrap / saturate / bounce / one-shot boundary handling.
module param_mode_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              dir_out,
  output logic              at_max,
  output logic              at_min,
  output logic              bound,
  output logic              done
);

  localparam int AW = WIDTH + 2;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [AW-1:0]    MAX_X = AW'(MAX_VAL);
  localparam logic [AW-1:0]    MOD_X = AW'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    res;
  logic             eff_up;
  logic             over;
  logic             hit;
  logic [WIDTH-1:0] load_clamped;

  // In bounce mode the registered direction drives the arithmetic; otherwise
  // the requested direction is used directly.
  always_comb begin
    cnt_x  = AW'(count);
    step_x = AW'(step);
    eff_up = (mode == MODE_BOUNCE) ? dir_out : dir;
    sum    = cnt_x + step_x;
    over   = 1'b0;
    hit    = 1'b0;
    res    = cnt_x;
    if (eff_up) begin
      over = (sum > MAX_X);
      hit  = (step_x != '0) && (sum >= MAX_X);
      if (over) res = (mode == MODE_WRAP) ? (sum - MOD_X) : MAX_X;
      else      res = sum;
    end else begin
      over = (step_x > cnt_x);
      hit  = (step_x != '0) && (step_x >= cnt_x);
      if (over) res = (mode == MODE_WRAP) ? (cnt_x + MOD_X - step_x) : '0;
      else      res = cnt_x - step_x;
    end
  end

  always_comb begin
    load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      dir_out <= 1'b1;
      bound   <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      dir_out <= dir;
      bound   <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      count   <= load_clamped;
      dir_out <= dir;
      bound   <= 1'b0;
      done    <= 1'b0;
    end else begin
      bound <= 1'b0;
      if (mode != MODE_ONESHOT) done <= 1'b0;
      if (en) begin
        if (mode != MODE_BOUNCE) dir_out <= dir;
        // A finished one-shot ignores enable until cleared, loaded or remoded.
        if (!done) begin
          count <= res[WIDTH-1:0];
          bound <= hit;
          if (hit && mode == MODE_BOUNCE)  dir_out <= ~dir_out;
          if (hit && mode == MODE_ONESHOT) done    <= 1'b1;
        end
      end
    end
  end

  assign at_max = (count == MAX_W);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_param_mode_counter.sv
// Bench for param_mode_counter: directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_param_mode_counter;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int STEP_W  = 4;

  logic              clk = 1'b0;
  logic              rst, en, clear, load, dir;
  logic [WIDTH-1:0]  load_val;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              dir_out, at_max, at_min, bound, done;

  int errors = 0;
  int checks = 0;

  // reference model state
  int   m_count;
  logic m_dir;
  logic m_bound;
  logic m_done;

  param_mode_counter #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode), .step(step),
    .count(count), .dir_out(dir_out), .at_max(at_max), .at_min(at_min),
    .bound(bound), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of one edge, from the current inputs.
  task automatic model_edge();
    int   target;
    logic up;
    logic reached;
    if (rst) begin
      m_count = 0; m_dir = 1'b1; m_bound = 1'b0; m_done = 1'b0;
    end else if (clear) begin
      m_count = 0; m_dir = dir; m_bound = 1'b0; m_done = 1'b0;
    end else if (load) begin
      m_count = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      m_dir = dir; m_bound = 1'b0; m_done = 1'b0;
    end else begin
      reached = 1'b0;
      up = (mode == 2'd2) ? m_dir : dir;
      if (en) begin
        if (mode != 2'd2) m_dir = dir;
        if (!m_done && step != 0) begin
          target  = up ? m_count + int'(step) : m_count - int'(step);
          reached = up ? (target >= MAX_VAL) : (target <= 0);
          if (mode == 2'd0) begin
            if (target > MAX_VAL) target -= (MAX_VAL + 1);
            if (target < 0)       target += (MAX_VAL + 1);
          end else begin
            if (target > MAX_VAL) target = MAX_VAL;
            if (target < 0)       target = 0;
            if (reached && mode == 2'd2) m_dir = ~m_dir;
          end
          m_count = target;
        end
      end
      m_bound = reached;
      m_done  = (mode == 2'd3) && (m_done || reached);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b1; mode = 2'd0; step = '0; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; en = 1'b1; step = 4'd1;
    tick(); tick();
    checks++;
    if (count !== 4'd0 || dir_out !== 1'b1 || at_min !== 1'b1 || at_max !== 1'b0 ||
        bound !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d dir_out=%b at_min=%b at_max=%b bound=%b done=%b, want 0 1 1 0 0 0",
               count, dir_out, at_min, at_max, bound, done);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (count !== 4'(i % 10) || bound !== (i >= 9)) begin
        errors++;
        $display("FAIL count_up step %0d: count=%0d bound=%b, want %0d %b",
                 i, count, bound, i % 10, (i >= 9));
      end
    end
  endtask

  task automatic test_wrap();
    int ec[3] = '{1, 8, 6};
    int eb[3] = '{1, 1, 0};
    int ed[3] = '{1, 0, 0};
    int es[3] = '{3, 3, 2};
    idle_inputs();
    load = 1'b1; load_val = 4'd8; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dir = ed[i][0]; step = 4'(es[i]);
      tick();
      checks++;
      if (count !== 4'(ec[i]) || bound !== eb[i][0]) begin
        errors++;
        $display("FAIL wrap %0d: count=%0d bound=%b, want %0d %0d", i, count, bound, ec[i], eb[i]);
      end
    end
  endtask

  task automatic test_saturate();
    idle_inputs();
    mode = 2'd1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    load = 1'b0; step = 4'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 4'd9 || bound !== 1'b1 || at_max !== 1'b1) begin
        errors++;
        $display("FAIL saturate_up %0d: count=%0d bound=%b at_max=%b, want 9 1 1", i, count, bound, at_max);
      end
    end
    dir = 1'b0; step = 4'd9;
    tick();
    checks++;
    if (count !== 4'd0 || at_min !== 1'b1 || bound !== 1'b1) begin
      errors++;
      $display("FAIL saturate_down: count=%0d at_min=%b bound=%b, want 0 1 1", count, at_min, bound);
    end
  endtask

  task automatic test_bounce();
    int ec[5] = '{9, 6, 3, 0, 3};
    int ed[5] = '{0, 0, 0, 1, 1};
    int eb[5] = '{1, 0, 0, 1, 0};
    idle_inputs();
    mode = 2'd2; load = 1'b1; load_val = 4'd8; en = 1'b1;
    tick();
    load = 1'b0; step = 4'd3;
    for (int i = 0; i < 5; i++) begin
      dir = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (count !== 4'(ec[i]) || dir_out !== ed[i][0] || bound !== eb[i][0]) begin
        errors++;
        $display("FAIL bounce %0d: count=%0d dir_out=%b bound=%b, want %0d %0d %0d",
                 i, count, dir_out, bound, ec[i], ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int ec[4] = '{1, 0, 0, 0};
    int edn[4] = '{0, 1, 1, 1};
    int eb[4] = '{0, 1, 0, 0};
    idle_inputs();
    mode = 2'd3; dir = 1'b0; load = 1'b1; load_val = 4'd2; en = 1'b1;
    tick();
    load = 1'b0; step = 4'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 4'(ec[i]) || done !== edn[i][0] || bound !== eb[i][0]) begin
        errors++;
        $display("FAIL oneshot %0d: count=%0d done=%b bound=%b, want %0d %0d %0d",
                 i, count, done, bound, ec[i], edn[i], eb[i]);
      end
    end
    load = 1'b1; load_val = 4'd5;
    tick();
    checks++;
    if (count !== 4'd5 || done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload: count=%0d done=%b, want 5 0", count, done);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    en = 1'b1; step = 4'd1; load = 1'b1; load_val = 4'd15;
    tick();
    checks++;
    if (count !== 4'd9) begin
      errors++;
      $display("FAIL load_clamp: count=%0d, want 9", count);
    end
    clear = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_load: count=%0d, want 0", count);
    end
    clear = 1'b0; dir = 1'b0; load_val = 4'd5;
    tick();
    checks++;
    if (count !== 4'd5 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL load_dir: count=%0d dir_out=%b, want 5 0", count, dir_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_over_load: count=%0d dir_out=%b, want 0 1", count, dir_out);
    end
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1'b1;
    model_edge();
    tick();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 4) != 0);
      dir      = 1'($urandom_range(0, 1));
      step     = 4'($urandom_range(0, MAX_VAL));
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      model_edge();
      tick();
      checks++;
      if (count !== 4'(m_count) || dir_out !== m_dir || bound !== m_bound || done !== m_done ||
          at_max !== (m_count == MAX_VAL) || at_min !== (m_count == 0)) begin
        errors++;
        $display("FAIL random %0d: count=%0d dir_out=%b bound=%b done=%b at_max=%b at_min=%b, want %0d %b %b %b %b %b",
                 i, count, dir_out, bound, done, at_max, at_min,
                 m_count, m_dir, m_bound, m_done, (m_count == MAX_VAL), (m_count == 0));
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_oneshot();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
